// File: rtl/vga_box_painter.sv
`default_nettype none
// ============================================================================
// Module   : vga_box_painter
// Purpose  : Raster write-stream source for a VGA framebuffer. Sweeps every
//            pixel of the active area once per frame, painting a square box
//            in the foreground colour over a background colour. Between
//            frames the box steps diagonally and bounces off the screen edges.
//            The downstream side may stall the stream via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module vga_box_painter #(
   parameter int H_W      = 11,
   parameter int V_W      = 11,
   parameter int COLOR_W  = 2,
   parameter int BOX_SIZE = 100,
   parameter int STEP     = 4,
   parameter int GAP_W    = 16
) (
   input  logic               clk_i,
   input  logic               arst_i,
   input  logic               enable_i,
   input  logic [H_W-1:0]     res_x_i,
   input  logic [V_W-1:0]     res_y_i,
   input  logic [GAP_W-1:0]   gap_i,
   input  logic [COLOR_W-1:0] fg_color_i,
   input  logic [COLOR_W-1:0] bg_color_i,
   input  logic               ready_i,
   output logic               we_o,
   output logic [H_W-1:0]     addr_x_o,
   output logic [V_W-1:0]     addr_y_o,
   output logic [COLOR_W-1:0] color_o,
   output logic               frame_done_o,
   output logic [H_W-1:0]     box_x_o,
   output logic [V_W-1:0]     box_y_o
);

   // -------------------------------------------------------------------------
   // Constants. Edge arithmetic is carried two bits wider than the coordinate
   // so box + BOX_SIZE + STEP can never wrap.
   // -------------------------------------------------------------------------
   localparam logic [H_W+1:0] c_BOX_XW  = (H_W+2)'(BOX_SIZE);
   localparam logic [H_W+1:0] c_STEP_XW = (H_W+2)'(STEP);
   localparam logic [V_W+1:0] c_BOX_YW  = (V_W+2)'(BOX_SIZE);
   localparam logic [V_W+1:0] c_STEP_YW = (V_W+2)'(STEP);
   localparam logic [H_W:0]   c_BOX_XC  = (H_W+1)'(BOX_SIZE);
   localparam logic [V_W:0]   c_BOX_YC  = (V_W+1)'(BOX_SIZE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_MOVE = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   // Frame-latched configuration
   logic [H_W-1:0]       r_res_x;
   logic [V_W-1:0]       r_res_y;
   logic [GAP_W-1:0]     r_gap;
   logic [GAP_W-1:0]     r_gap_cnt;

   // Write stream
   logic                 r_we;
   logic [H_W-1:0]       r_x;
   logic [V_W-1:0]       r_y;
   logic                 r_frame_done;

   // Box position and direction (1 = moving towards larger coordinates)
   logic [H_W-1:0]       r_box_x;
   logic [V_W-1:0]       r_box_y;
   logic                 r_dir_x;
   logic                 r_dir_y;
   logic [H_W-1:0]       w_box_x_nxt;
   logic [V_W-1:0]       w_box_y_nxt;
   logic                 w_dir_x_nxt;
   logic                 w_dir_y_nxt;

   // Control decodes
   logic                 w_xfer;
   logic                 w_last_x;
   logic                 w_last_y;
   logic                 w_frame_end;
   logic                 w_gap_end;
   logic                 w_start;

   // Extended operands for bounce and colour comparisons
   logic [H_W+1:0]       w_res_x_ext;
   logic [H_W+1:0]       w_bx_ext;
   logic [V_W+1:0]       w_res_y_ext;
   logic [V_W+1:0]       w_by_ext;
   logic [H_W:0]         w_x_c;
   logic [H_W:0]         w_bx_c;
   logic [V_W:0]         w_y_c;
   logic [V_W:0]         w_by_c;
   logic                 w_in_x;
   logic                 w_in_y;

   assign w_xfer      = r_we & ready_i;
   assign w_last_x    = (r_x == r_res_x - H_W'(1));
   assign w_last_y    = (r_y == r_res_y - V_W'(1));
   assign w_frame_end = (r_state == S_SCAN) & w_xfer & w_last_x & w_last_y;
   assign w_gap_end   = (r_gap_cnt == r_gap);

   // State register
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; w_start marks a frame launch (config latch + addr 0,0)
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable_i) begin
               w_state_nxt = S_SCAN;
               w_start     = 1'b1;
            end
         end
         S_SCAN: begin
            if (w_frame_end) begin
               w_state_nxt = S_MOVE;
            end
         end
         S_MOVE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_gap_end) begin
               if (enable_i) begin
                  w_state_nxt = S_SCAN;
                  w_start     = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Raster address generation, frame configuration latch and done pulse
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_res_x      <= '0;
         r_res_y      <= '0;
         r_gap        <= '0;
         r_we         <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_start) begin
            r_res_x <= res_x_i;
            r_res_y <= res_y_i;
            r_gap   <= gap_i;
            r_x     <= '0;
            r_y     <= '0;
            r_we    <= 1'b1;
         end else if ((r_state == S_SCAN) && w_xfer) begin
            if (w_last_x) begin
               r_x <= '0;
               if (w_last_y) begin
                  r_y  <= '0;
                  r_we <= 1'b0;
               end else begin
                  r_y <= r_y + V_W'(1);
               end
            end else begin
               r_x <= r_x + H_W'(1);
            end
         end
      end
   end

   // Inter-frame wait counter: cleared in MOVE, counts up to the latched gap
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_gap_cnt <= '0;
      end else if (r_state == S_MOVE) begin
         r_gap_cnt <= '0;
      end else if ((r_state == S_WAIT) && !w_gap_end) begin
         r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
   end

   assign w_res_x_ext = {2'b00, r_res_x};
   assign w_bx_ext    = {2'b00, r_box_x};
   assign w_res_y_ext = {2'b00, r_res_y};
   assign w_by_ext    = {2'b00, r_box_y};

   // Horizontal bounce: clamp to the far edge or zero and reverse direction
   always_comb begin
      w_box_x_nxt = r_box_x;
      w_dir_x_nxt = r_dir_x;
      if (w_res_x_ext < c_BOX_XW) begin
         w_box_x_nxt = '0;
      end else if (r_dir_x) begin
         if (w_bx_ext + c_BOX_XW + c_STEP_XW >= w_res_x_ext) begin
            w_box_x_nxt = r_res_x - H_W'(BOX_SIZE);
            w_dir_x_nxt = 1'b0;
         end else begin
            w_box_x_nxt = r_box_x + H_W'(STEP);
         end
      end else begin
         if (w_bx_ext < c_STEP_XW) begin
            w_box_x_nxt = '0;
            w_dir_x_nxt = 1'b1;
         end else begin
            w_box_x_nxt = r_box_x - H_W'(STEP);
         end
      end
   end

   // Vertical bounce: same rule as horizontal, against the latched height
   always_comb begin
      w_box_y_nxt = r_box_y;
      w_dir_y_nxt = r_dir_y;
      if (w_res_y_ext < c_BOX_YW) begin
         w_box_y_nxt = '0;
      end else if (r_dir_y) begin
         if (w_by_ext + c_BOX_YW + c_STEP_YW >= w_res_y_ext) begin
            w_box_y_nxt = r_res_y - V_W'(BOX_SIZE);
            w_dir_y_nxt = 1'b0;
         end else begin
            w_box_y_nxt = r_box_y + V_W'(STEP);
         end
      end else begin
         if (w_by_ext < c_STEP_YW) begin
            w_box_y_nxt = '0;
            w_dir_y_nxt = 1'b1;
         end else begin
            w_box_y_nxt = r_box_y - V_W'(STEP);
         end
      end
   end

   // Box position register, advanced once per frame in MOVE
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_box_x <= '0;
         r_box_y <= '0;
         r_dir_x <= 1'b1;
         r_dir_y <= 1'b1;
      end else if (r_state == S_MOVE) begin
         r_box_x <= w_box_x_nxt;
         r_box_y <= w_box_y_nxt;
         r_dir_x <= w_dir_x_nxt;
         r_dir_y <= w_dir_y_nxt;
      end
   end

   // Colour tracks the presented address; forced to zero when no write is valid
   assign w_x_c  = {1'b0, r_x};
   assign w_bx_c = {1'b0, r_box_x};
   assign w_y_c  = {1'b0, r_y};
   assign w_by_c = {1'b0, r_box_y};
   assign w_in_x = (w_x_c >= w_bx_c) && (w_x_c < w_bx_c + c_BOX_XC);
   assign w_in_y = (w_y_c >= w_by_c) && (w_y_c < w_by_c + c_BOX_YC);

   assign color_o      = !r_we ? '0 : ((w_in_x && w_in_y) ? fg_color_i : bg_color_i);
   assign we_o         = r_we;
   assign addr_x_o     = r_x;
   assign addr_y_o     = r_y;
   assign frame_done_o = r_frame_done;
   assign box_x_o      = r_box_x;
   assign box_y_o      = r_box_y;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_painter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_box_painter
// Purpose  : Self-checking bench for vga_box_painter. A pixel-index model of
//            the frame (raster index, latched resolution, box position and
//            bounce) predicts every presented write, the frame-done pulse and
//            the inter-frame timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_box_painter;
   localparam int H_W     = 11;
   localparam int V_W     = 11;
   localparam int COLOR_W = 2;
   localparam int BOX     = 2;
   localparam int STP     = 1;
   localparam int GAP_W   = 16;

   logic               clk_i      = 1'b0;
   logic               arst_i     = 1'b1;
   logic               enable_i   = 1'b0;
   logic [H_W-1:0]     res_x_i    = 11'd8;
   logic [V_W-1:0]     res_y_i    = 11'd6;
   logic [GAP_W-1:0]   gap_i      = '0;
   logic [COLOR_W-1:0] fg_color_i = 2'd1;
   logic [COLOR_W-1:0] bg_color_i = 2'd0;
   logic               ready_i    = 1'b0;
   logic               we_o;
   logic [H_W-1:0]     addr_x_o;
   logic [V_W-1:0]     addr_y_o;
   logic [COLOR_W-1:0] color_o;
   logic               frame_done_o;
   logic [H_W-1:0]     box_x_o;
   logic [V_W-1:0]     box_y_o;

   vga_box_painter #(
      .H_W(H_W), .V_W(V_W), .COLOR_W(COLOR_W),
      .BOX_SIZE(BOX), .STEP(STP), .GAP_W(GAP_W)
   ) u_dut (
      .clk_i(clk_i), .arst_i(arst_i), .enable_i(enable_i),
      .res_x_i(res_x_i), .res_y_i(res_y_i), .gap_i(gap_i),
      .fg_color_i(fg_color_i), .bg_color_i(bg_color_i), .ready_i(ready_i),
      .we_o(we_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .color_o(color_o),
      .frame_done_o(frame_done_o), .box_x_o(box_x_o), .box_y_o(box_y_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   int m_rx, m_ry, m_gap, m_p;
   bit m_in_frame;
   int m_bx, m_by, m_dx, m_dy;
   bit m_have_done;
   int cyc, done_cyc, frames, n_xfer, n_fg, last_x, last_y;
   int rmode, rpat;
   int start_bx[$];
   int start_by[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [COLOR_W-1:0] exp_color(input int x, input int y);
      if (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) return fg_color_i;
      return bg_color_i;
   endfunction

   task automatic move_axis(inout int pos, inout int dir, input int res);
      if (res < BOX) begin
         pos = 0;
      end else if (dir > 0) begin
         if (pos + BOX + STP >= res) begin pos = res - BOX; dir = -1; end
         else pos = pos + STP;
      end else begin
         if (pos < STP) begin pos = 0; dir = 1; end
         else pos = pos - STP;
      end
   endtask

   task automatic model_reset();
      m_in_frame = 0; m_p = 0;
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      m_have_done = 0; frames = 0; n_xfer = 0; n_fg = 0; rpat = 0;
      start_bx.delete(); start_by.delete();
   endtask

   // One clock: drive ready, check the presented write, advance the model
   task automatic step();
      logic               rdy, pw, en_e, lastp;
      logic [H_W-1:0]     px;
      logic [V_W-1:0]     py;
      logic [COLOR_W-1:0] pc;
      int                 rx_e, ry_e, gap_e;
      case (rmode)
         0:       rdy = 1'b1;
         1:       begin rdy = ((rpat % 4) == 0) || ((rpat % 4) == 3); rpat++; end
         2:       rdy = 1'($urandom_range(0, 1));
         default: rdy = 1'b0;
      endcase
      ready_i = rdy;
      if (m_in_frame) begin
         chk("we_in_frame", we_o, 1);
         chk("addr_x", addr_x_o, m_p % m_rx);
         chk("addr_y", addr_y_o, m_p / m_rx);
         chk("color", color_o, exp_color(m_p % m_rx, m_p / m_rx));
      end else begin
         chk("we_idle", we_o, 0);
      end
      pw = we_o; px = addr_x_o; py = addr_y_o; pc = color_o;
      rx_e = res_x_i; ry_e = res_y_i; gap_e = gap_i; en_e = enable_i;
      @(posedge clk_i); #1;
      cyc++;
      lastp = 1'b0;
      if (pw && rdy) begin
         m_p++; n_xfer++;
         if (pc == fg_color_i) n_fg++;
         last_x = px; last_y = py;
         lastp = (m_p == m_rx * m_ry);
      end
      if (pw && !rdy) begin
         chk("stall_x", addr_x_o, px);
         chk("stall_y", addr_y_o, py);
         chk("stall_color", color_o, pc);
      end
      chk("frame_done", frame_done_o, lastp);
      if (lastp) begin
         chk("we_drop", we_o, 0);
         m_in_frame = 0; frames++;
         move_axis(m_bx, m_dx, m_rx);
         move_axis(m_by, m_dy, m_ry);
         done_cyc = cyc; m_have_done = 1;
      end
      if (!pw && we_o) begin
         chk("start_enabled", en_e, 1);
         chk("start_box_x", box_x_o, m_bx);
         chk("start_box_y", box_y_o, m_by);
         if (m_have_done) chk("frame_gap", cyc - done_cyc, m_gap + 2);
         start_bx.push_back(int'(box_x_o));
         start_by.push_back(int'(box_y_o));
         m_in_frame = 1; m_p = 0; m_rx = rx_e; m_ry = ry_e; m_gap = gap_e;
      end
   endtask

   // Asynchronous reset asserted mid-cycle; released at the usual sample point
   task automatic apply_reset(input bit check_zero);
      #2 arst_i = 1'b1;
      #1;
      if (check_zero) begin
         chk("rst_we", we_o, 0);
         chk("rst_addr_x", addr_x_o, 0);
         chk("rst_addr_y", addr_y_o, 0);
         chk("rst_color", color_o, 0);
         chk("rst_done", frame_done_o, 0);
         chk("rst_box_x", box_x_o, 0);
         chk("rst_box_y", box_y_o, 0);
      end
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 arst_i = 1'b0;
   endtask

   task automatic run_frames(input int n, input int budget);
      int k = 0;
      while (frames < n && k < budget) begin step(); k++; end
      if (frames < n) chk("timeout_frames", frames, n);
   endtask

   task automatic run_to_pixel(input int p, input int budget);
      int k = 0;
      while (!(m_in_frame && m_p == p) && k < budget) begin step(); k++; end
      if (!(m_in_frame && m_p == p)) chk("timeout_pixel", m_p, p);
   endtask

   int exp_bx[10] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3};
   int exp_by[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 0};

   initial begin
      cyc = 0; rmode = 0;
      model_reset();
      @(posedge clk_i); #1;
      apply_reset(1'b1);

      // Small frame, no stalls
      res_x_i = 8; res_y_i = 6; gap_i = 0; fg_color_i = 1; bg_color_i = 0;
      enable_i = 1; rmode = 0;
      run_frames(1, 200);
      chk("f1_writes", n_xfer, 48);
      chk("f1_fg_pixels", n_fg, 4);
      step();
      chk("box_after_f1_x", box_x_o, 1);
      chk("box_after_f1_y", box_y_o, 1);

      // Backpressure pattern 1,0,0,1
      apply_reset(1'b0);
      rmode = 1;
      run_frames(1, 400);
      chk("bp_writes", n_xfer, 48);

      // Bounce over ten frames with random gap and colours
      apply_reset(1'b0);
      rmode = 0;
      gap_i = GAP_W'($urandom_range(0, 3));
      fg_color_i = COLOR_W'($urandom_range(1, 3));
      bg_color_i = COLOR_W'($urandom_range(0, 3));
      run_frames(10, 1200);
      chk("bounce_starts", start_bx.size(), 10);
      for (int i = 0; i < 10 && i < start_bx.size(); i++) begin
         chk($sformatf("bounce_x%0d", i), start_bx[i], exp_bx[i]);
         chk($sformatf("bounce_y%0d", i), start_by[i], exp_by[i]);
      end

      // Enable dropped mid-frame under random backpressure
      apply_reset(1'b0);
      rmode = 2;
      gap_i = GAP_W'($urandom_range(0, 5));
      run_to_pixel(20, 300);
      enable_i = 0;
      run_frames(1, 400);
      repeat (int'(gap_i) + 20) step();
      chk("drop_idle_we", we_o, 0);
      chk("drop_writes", n_xfer, 48);

      // Resolution change mid-frame takes effect next frame
      apply_reset(1'b0);
      enable_i = 1; rmode = 0; gap_i = 1;
      run_to_pixel(10, 100);
      res_x_i = 4; res_y_i = 4;
      run_frames(1, 200);
      chk("res_f1_end_x", last_x, 7);
      chk("res_f1_end_y", last_y, 5);
      run_frames(2, 200);
      chk("res_f2_end_x", last_x, 3);
      chk("res_f2_end_y", last_y, 3);

      // Reset while stalled at (3,2) in the second frame
      apply_reset(1'b0);
      res_x_i = 8; res_y_i = 6; gap_i = 0; rmode = 0;
      run_frames(1, 200);
      run_to_pixel(19, 100);
      chk("stall_at_x", addr_x_o, 3);
      chk("stall_at_y", addr_y_o, 2);
      rmode = 3;
      repeat (2) step();
      apply_reset(1'b1);
      rmode = 0;
      run_to_pixel(0, 20);
      chk("restart_x", addr_x_o, 0);
      chk("restart_y", addr_y_o, 0);
      run_frames(1, 200);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_box_painter.md
Name: vga_box_painter

Overview:
- Upstream write-stream source for the VGA framebuffer in vga_top.
- Sweeps every pixel of the active resolution once per frame. Emits one write per pixel: foreground colour inside a square box, background colour elsewhere.
- Between frames, moves the box one step diagonally and bounces it off the screen edges.
- The framebuffer side may stall the stream through a valid/ready handshake.

Parameters:
- H_W, 11, width of x coordinates and res_x_i
- V_W, 11, width of y coordinates and res_y_i
- COLOR_W, 2, colour code width
- BOX_SIZE, 100, box edge length in pixels
- STEP, 4, box displacement per axis per frame
- GAP_W, 16, width of the inter-frame wait counter

Ports:
- clk_i  in  1  pixel-domain clock
- arst_i  in  1  asynchronous reset, active-high
- enable_i  in  1  run request; sampled in IDLE and at end of each frame
- res_x_i  in  H_W  active width; latched at frame start
- res_y_i  in  V_W  active height; latched at frame start
- gap_i  in  GAP_W  idle cycles between frames; latched at frame start
- fg_color_i  in  COLOR_W  colour inside box
- bg_color_i  in  COLOR_W  colour outside box
- ready_i  in  1  downstream accepts current write
- we_o  out  1  write valid
- addr_x_o  out  H_W  write x
- addr_y_o  out  V_W  write y
- color_o  out  COLOR_W  write colour
- frame_done_o  out  1  one-cycle pulse after last pixel of a frame accepted
- box_x_o  out  H_W  current box left edge
- box_y_o  out  V_W  current box top edge

Behaviour:
- Reset (async assert, sync release): state IDLE, we_o=0, addr_x_o=0, addr_y_o=0, color_o=0, frame_done_o=0, box_x_o=0, box_y_o=0, both directions positive, wait counter 0.
- States: IDLE, SCAN, MOVE, WAIT.
- IDLE -> SCAN when enable_i=1.
  - On this transition, latch res_x_i, res_y_i and gap_i.
  - Set addr to (0,0) and assert we_o on the next cycle.
- SCAN: we_o=1 continuously.
  - A transfer occurs on a cycle with we_o && ready_i.
  - While ready_i=0, addr_x_o, addr_y_o and color_o hold stable.
  - Transfer order is raster: x increments. At x=res_x-1, x wraps to 0 and y increments.
  - Transfer at (res_x-1, res_y-1) -> MOVE. we_o drops the next cycle and frame_done_o pulses for 1 cycle.
- color_o is combinationally consistent with the presented address:
  - fg_color_i when box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE;
  - bg_color_i otherwise.
  - Compare in H_W+1 / V_W+1 bits so box_x+BOX_SIZE never overflows.
- MOVE (1 cycle), per axis, shown for x (y is identical with res_y):
  - Positive direction, box_x+BOX_SIZE+STEP >= res_x: box_x = res_x-BOX_SIZE, direction becomes negative.
  - Positive direction otherwise: box_x += STEP.
  - Negative direction, box_x < STEP: box_x = 0, direction becomes positive.
  - Negative direction otherwise: box_x -= STEP.
  - Both axes update in the same cycle.
  - If res_x < BOX_SIZE (or res_y < BOX_SIZE), that axis holds at 0 and its direction is unchanged.
  - MOVE -> WAIT.
- WAIT: count gap cycles; gap=0 gives 0 extra cycles. At the end:
  - enable_i=1: -> SCAN with a fresh latch of res/gap.
  - enable_i=0: -> IDLE.
- enable_i deasserted mid-SCAN: the frame completes, then MOVE and WAIT run, then IDLE.
- res_x_i / res_y_i changes mid-frame are ignored until the next frame latch.
- Reset mid-frame: immediate return to reset values. No partial-frame completion and no frame_done_o pulse.
- Throughput: with ready_i=1, one pixel per cycle. Frame period = res_x*res_y + 1 (MOVE) + gap + 1 (WAIT→SCAN) cycles.

Test Plan:
1. Small frame: BOX_SIZE=2, STEP=1, res=8x6, gap=0, ready_i=1, fg=1, bg=0, enable_i=1.
   - 48 writes in raster order.
   - color_o=1 exactly at (0,0),(1,0),(0,1),(1,1).
   - frame_done_o pulses once; box moves to (1,1).
2. Backpressure: same config, ready_i toggling 1,0,0,1 repeatedly.
   - addr/color are stable across every stalled cycle.
   - Exactly 48 transfers, no skips or duplicates.
3. Bounce: res=8x6, run 10 frames.
   - box_x_o sequence 0,1,2,3,4,5,6,5,4,3,...
   - box_y_o sequence 0,1,2,3,4,3,2,...
   - Box never exceeds res-BOX_SIZE.
4. Enable drop: deassert enable_i at pixel 20 of frame 1.
   - Frame 1 completes (48 writes), frame_done_o pulses.
   - After gap, FSM is in IDLE with we_o=0 and no further writes.
5. Resolution change: change res to 4x4 mid-frame.
   - Current frame still ends at (7,5).
   - Next frame ends at (3,3).
6. Reset: assert arst_i while SCAN is stalled at (3,2).
   - All outputs return to 0 asynchronously.
   - After release with enable_i=1, the frame restarts at (0,0).
